// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor controller.
// Letters are 5-bit codes 0..25. Position arithmetic is always mod 26.
// Optional SET_DEC_EN build adds decrement in rotor-setting mode.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int      LETTERS     = 26;
  localparam letter_t LAST_LETTER = 5'(LETTERS - 1);

  typedef enum logic [1:0] {SEL_R1, SEL_R2, SEL_R3, SEL_NONE} rotor_sel_t;
  typedef enum logic [1:0] {IDLE, STEP, WAIT, LATCH} ctrl_state_t;

  // Historical turnover letters: R1 carries at V, R2 carries/double-steps at E
  localparam letter_t DEF_NOTCH1 = 5'd21;
  localparam letter_t DEF_NOTCH2 = 5'd4;

  function automatic letter_t letter_inc(input letter_t l);
    return (l == LAST_LETTER) ? 5'd0 : l + 5'd1;
  endfunction

  function automatic letter_t letter_dec(input letter_t l);
    return (l == 5'd0) ? LAST_LETTER : l - 5'd1;
  endfunction

endpackage

// File: rtl/enigma_rotor_ctrl_if.sv
// Keypad/setting/cipher-network bundle for enigma_rotor_ctrl.
// master = stimulus side, slave = the controller.
// SET_DEC only exists in builds with SET_DEC_EN defined.
interface enigma_rotor_ctrl_if;
  import enigma_pkg::*;

  logic       KEY_VALID;
  letter_t    KEY_LET;
  logic       SET_MODE;
  logic [1:0] SET_SEL;
  logic       SET_INC;
`ifdef SET_DEC_EN
  logic       SET_DEC;
`endif
  letter_t    CIPH_IN;
  letter_t    KEY_OUT;
  letter_t    R1;
  letter_t    R2;
  letter_t    R3;
  letter_t    LET;
  logic       ON;
  logic       BUSY;

  modport master (
`ifdef SET_DEC_EN
    output SET_DEC,
`endif
    output KEY_VALID, KEY_LET, SET_MODE, SET_SEL, SET_INC, CIPH_IN,
    input  KEY_OUT, R1, R2, R3, LET, ON, BUSY
  );

  modport slave (
`ifdef SET_DEC_EN
    input  SET_DEC,
`endif
    input  KEY_VALID, KEY_LET, SET_MODE, SET_SEL, SET_INC, CIPH_IN,
    output KEY_OUT, R1, R2, R3, LET, ON, BUSY
  );

endinterface

// File: rtl/enigma_rotor_ctrl_rotor_counter.sv
// One rotor position: mod-26 register with inc (and dec under SET_DEC_EN).
// Latency: position updates on the clock edge after the enable.
// No backpressure: enables are single-cycle strobes; inc+dec together cancel.
module rotor_counter
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH = DEF_NOTCH1
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    inc_i,
`ifdef SET_DEC_EN
  input  logic    dec_i,
`endif
  output letter_t pos_o,
  output logic    at_notch_o
);

  letter_t pos_q, pos_d;

  // Next position: step forward/back with wrap, opposing strobes cancel
  always_comb begin
    pos_d = pos_q;
`ifdef SET_DEC_EN
    if (inc_i && !dec_i)      pos_d = letter_inc(pos_q);
    else if (dec_i && !inc_i) pos_d = letter_dec(pos_q);
`else
    if (inc_i)                pos_d = letter_inc(pos_q);
`endif
  end

  // Position register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pos_q <= '0;
    else          pos_q <= pos_d;
  end

  assign pos_o      = pos_q;
  assign at_notch_o = (pos_q == NOTCH);

endmodule

// File: rtl/enigma_rotor_ctrl.sv
// Rotor stepping (with double-step) and cipher-letter latch for the Enigma display path.
// Latency: key at edge 0 -> rotors at edge 1 -> LET/ON after edge 2+SETTLE.
// No backpressure: keys/set strobes arriving while BUSY are dropped. Macro SET_DEC_EN adds SET_DEC.
module enigma_rotor_ctrl
  import enigma_pkg::*;
#(
  parameter letter_t     NOTCH1 = DEF_NOTCH1,
  parameter letter_t     NOTCH2 = DEF_NOTCH2,
  parameter int unsigned SETTLE = 2
) (
  input logic               CLK,
  input logic               RST_N,
  enigma_rotor_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_STEP  = 2'(STEP);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);
  localparam logic [1:0] ST_LATCH = 2'(LATCH);

  // Out-of-range SETTLE values are clamped to 1..15
  localparam logic [3:0] SETTLE_CNT = (SETTLE < 1)  ? 4'd1  :
                                      (SETTLE > 15) ? 4'd15 : 4'(SETTLE);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  letter_t    key_q, key_d;
  letter_t    let_q, let_d;
  logic       on_q, on_d;

  letter_t    r1_pos, r2_pos, r3_pos;
  logic       r1_notch, r2_notch, r3_notch_unused;
  logic       r1_inc, r2_inc, r3_inc;
  logic       idle, step, set_inc_en, set_any;
  rotor_sel_t sel;

  assign idle       = (state_q == ST_IDLE);
  assign step       = (state_q == ST_STEP);
  assign sel        = rotor_sel_t'(bus.SET_SEL);
  assign set_inc_en = idle && bus.SET_MODE && bus.SET_INC;

`ifdef SET_DEC_EN
  logic set_dec_en;
  assign set_dec_en = idle && bus.SET_MODE && bus.SET_DEC;
  assign set_any    = set_inc_en || set_dec_en;
`else
  assign set_any    = set_inc_en;
`endif

  // Stepping uses pre-step notch flags: R2 at its notch moves itself and R3 (double-step)
  assign r1_inc = step || (set_inc_en && sel == SEL_R1);
  assign r2_inc = (step && (r1_notch || r2_notch)) || (set_inc_en && sel == SEL_R2);
  assign r3_inc = (step && r2_notch) || (set_inc_en && sel == SEL_R3);

  rotor_counter #(.NOTCH(NOTCH1)) u_r1 (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .inc_i      (r1_inc),
`ifdef SET_DEC_EN
    .dec_i      (set_dec_en && sel == SEL_R1),
`endif
    .pos_o      (r1_pos),
    .at_notch_o (r1_notch)
  );

  rotor_counter #(.NOTCH(NOTCH2)) u_r2 (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .inc_i      (r2_inc),
`ifdef SET_DEC_EN
    .dec_i      (set_dec_en && sel == SEL_R2),
`endif
    .pos_o      (r2_pos),
    .at_notch_o (r2_notch)
  );

  // Leftmost rotor has no rotor beyond it, so its notch flag goes nowhere
  rotor_counter #(.NOTCH(NOTCH2)) u_r3 (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .inc_i      (r3_inc),
`ifdef SET_DEC_EN
    .dec_i      (set_dec_en && sel == SEL_R3),
`endif
    .pos_o      (r3_pos),
    .at_notch_o (r3_notch_unused)
  );

  // Control FSM: accept key in IDLE, step once, settle SETTLE cycles, latch cipher letter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    let_d   = let_q;
    on_d    = on_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.SET_MODE) begin
          if (set_any) on_d = 1'b0;
        end else if (bus.KEY_VALID && bus.KEY_LET <= LAST_LETTER) begin
          key_d   = bus.KEY_LET;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        cnt_d   = SETTLE_CNT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) state_d = ST_LATCH;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_LATCH: begin
        let_d   = bus.CIPH_IN;
        on_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any in-flight key with no partial latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      let_q   <= '0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      let_q   <= let_d;
      on_q    <= on_d;
    end
  end

  assign bus.KEY_OUT = key_q;
  assign bus.R1      = r1_pos;
  assign bus.R2      = r2_pos;
  assign bus.R3      = r3_pos;
  assign bus.LET     = let_q;
  assign bus.ON      = on_q;
  assign bus.BUSY    = !idle;

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// Scoreboard bench for enigma_rotor_ctrl: directed scenarios then random keys/settings.
// Expected results come from a mod-26 reference model of the rotor rules.
// Define SET_DEC_EN to also exercise the decrement path.
module tb_enigma_rotor_ctrl;
  import enigma_pkg::*;

  logic CLK;
  logic RST_N;
  enigma_rotor_ctrl_if bus();

  enigma_rotor_ctrl #(.NOTCH1(5'd21), .NOTCH2(5'd4), .SETTLE(2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int r1;
    int r2;
    int r3;
    int let_v;
    int key;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   abort_pending = 1'b0;

  // Reference model state: rotor positions (index 0 = R1), key, latched letter, ON
  int   m_r[3];
  int   m_key, m_let;
  bit   m_on;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_r[0] = 0; m_r[1] = 0; m_r[2] = 0;
    m_key = 0; m_let = 0; m_on = 1'b0;
  endtask

  // Keypress rule: R1 always turns; R2 on R1 at V or R2 at E; R3 on R2 at E
  task automatic model_step();
    bit mv2, mv3;
    mv2 = (m_r[0] == 21) || (m_r[1] == 4);
    mv3 = (m_r[1] == 4);
    m_r[0] = (m_r[0] + 1) % 26;
    if (mv2) m_r[1] = (m_r[1] + 1) % 26;
    if (mv3) m_r[2] = (m_r[2] + 1) % 26;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_r1"},   int'(bus.R1),      m_r[0]);
    chk({tag, "_r2"},   int'(bus.R2),      m_r[1]);
    chk({tag, "_r3"},   int'(bus.R3),      m_r[2]);
    chk({tag, "_on"},   int'(bus.ON),      int'(m_on));
    chk({tag, "_key"},  int'(bus.KEY_OUT), m_key);
    chk({tag, "_busy"}, int'(bus.BUSY),    0);
  endtask

  // Called at a negedge with the DUT idle; returns at a later negedge with the DUT idle
  task automatic press(input int l, input int c, input bit extra);
    exp_t e;
    int   n;
    int   old_let;
    bit   old_on;
    bus.SET_MODE  = 1'b0;
    bus.SET_INC   = 1'b0;
    bus.KEY_VALID = 1'b1;
    bus.KEY_LET   = 5'(l);
    if (l > 25) begin
      @(negedge CLK);
      bus.KEY_VALID = 1'b0;
      compare_all("badkey");
      return;
    end
    old_let = m_let;
    old_on  = m_on;
    model_step();
    m_key   = l;
    e.r1 = m_r[0]; e.r2 = m_r[1]; e.r3 = m_r[2]; e.let_v = c; e.key = l;
    exp_q.push_back(e);
    @(negedge CLK);
    bus.KEY_VALID = extra;
    bus.KEY_LET   = 5'($urandom_range(0, 25));
    bus.CIPH_IN   = 5'(c);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.KEY_VALID = 1'b0;
      chk("busy_during_key", int'(bus.BUSY), 1);
      chk("on_held_during_key", int'(bus.ON), int'(old_on));
      chk("let_held_during_key", int'(bus.LET), old_let);
    end
    n = 0;
    while (bus.BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("key_done_busy", int'(bus.BUSY), 0);
    chk("latch_extra_cycles", n, 1);
    m_on  = 1'b1;
    m_let = c;
    @(negedge CLK);
  endtask

  task automatic set_op(input int sel, input bit inc, input bit dec);
    bus.SET_MODE  = 1'b1;
    bus.SET_SEL   = 2'(sel);
    bus.SET_INC   = inc;
`ifdef SET_DEC_EN
    bus.SET_DEC   = dec;
`endif
    bus.KEY_VALID = 1'($urandom_range(0, 1));
    bus.KEY_LET   = 5'($urandom_range(0, 25));
    @(negedge CLK);
    bus.SET_INC   = 1'b0;
`ifdef SET_DEC_EN
    bus.SET_DEC   = 1'b0;
`endif
    bus.KEY_VALID = 1'b0;
    if (sel < 3) begin
`ifdef SET_DEC_EN
      if (inc && !dec)      m_r[sel] = (m_r[sel] + 1) % 26;
      else if (dec && !inc) m_r[sel] = (m_r[sel] + 25) % 26;
`else
      if (inc)              m_r[sel] = (m_r[sel] + 1) % 26;
`endif
    end
    if (inc || dec) m_on = 1'b0;
    compare_all("set");
  endtask

  task automatic set_rotor(input int sel, input int target);
    for (int k = 0; k < 26 && m_r[sel] != target; k++) set_op(sel, 1'b1, 1'b0);
  endtask

  // Monitor: each return to IDLE presents a finished key; pop and compare
  initial begin
    exp_t e;
    bit   prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST_N && prev_busy && !bus.BUSY) begin
        if (exp_q.size() == 0) begin
          if (abort_pending) abort_pending = 1'b0;
          else chk("sb_unexpected_output", int'(bus.LET), -1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_let", int'(bus.LET),     e.let_v);
          chk("sb_on",  int'(bus.ON),      1);
          chk("sb_r1",  int'(bus.R1),      e.r1);
          chk("sb_r2",  int'(bus.R2),      e.r2);
          chk("sb_r3",  int'(bus.R3),      e.r3);
          chk("sb_key", int'(bus.KEY_OUT), e.key);
        end
      end
      prev_busy = bus.BUSY && RST_N;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    RST_N         = 1'b0;
    bus.KEY_VALID = 1'b0;
    bus.KEY_LET   = '0;
    bus.SET_MODE  = 1'b0;
    bus.SET_SEL   = '0;
    bus.SET_INC   = 1'b0;
`ifdef SET_DEC_EN
    bus.SET_DEC   = 1'b0;
`endif
    bus.CIPH_IN   = '0;
    model_reset();
    #12;
    compare_all("reset");
    chk("reset_let", int'(bus.LET), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Latch timing: CIPH_IN=7 from edge 1, LET/ON first visible after edge 4
    press(5, 7, 1'b0);
    chk("timing_let", int'(bus.LET), 7);
    chk("timing_on",  int'(bus.ON),  1);

    // Second strobe one cycle after the first is dropped: exactly one step
    press(3, 12, 1'b1);
    chk("drop_r1", int'(bus.R1), 2);

    // Out-of-range letter in IDLE changes nothing
    press(28, 0, 1'b0);

    // Double-step sequence from R3,R2,R1 = 0,3,20
    set_rotor(2, 0);
    set_rotor(1, 3);
    set_rotor(0, 20);
    press(0, 1, 1'b0);
    chk("ds1_r3", int'(bus.R3), 0);
    chk("ds1_r2", int'(bus.R2), 3);
    chk("ds1_r1", int'(bus.R1), 21);
    press(0, 2, 1'b0);
    chk("ds2_r3", int'(bus.R3), 0);
    chk("ds2_r2", int'(bus.R2), 4);
    chk("ds2_r1", int'(bus.R1), 22);
    press(0, 3, 1'b0);
    chk("ds3_r3", int'(bus.R3), 1);
    chk("ds3_r2", int'(bus.R2), 5);
    chk("ds3_r1", int'(bus.R1), 23);

    // Wrap and set: ON cleared by the first increment, R1 wraps 25 -> 0
    press(7, 9, 1'b0);
    set_op(0, 1'b1, 1'b0);
    chk("set_clears_on", int'(bus.ON), 0);
    set_rotor(0, 25);
    set_op(0, 1'b1, 1'b0);
    chk("wrap_r1", int'(bus.R1), 0);
    set_op(3, 1'b1, 1'b0);
    chk("sel_none_r1", int'(bus.R1), 0);

`ifdef SET_DEC_EN
    set_rotor(1, 0);
    set_op(1, 1'b0, 1'b1);
    chk("dec_wrap_r2", int'(bus.R2), 25);
    set_op(1, 1'b1, 1'b1);
    chk("incdec_r2", int'(bus.R2), 25);
`endif

    // Reset in the middle of WAIT aborts the key
    bus.SET_MODE  = 1'b0;
    bus.KEY_VALID = 1'b1;
    bus.KEY_LET   = 5'd9;
    bus.CIPH_IN   = 5'd11;
    @(negedge CLK);
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_reset_busy", int'(bus.BUSY), 1);
    #2;
    abort_pending = 1'b1;
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all("midwait_reset");
    chk("midwait_reset_let", int'(bus.LET), 0);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    press(17, 4, 1'b0);

    // Random mix of settings, valid keys (with dropped extras) and bad letters
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      if (op < 3) begin
`ifdef SET_DEC_EN
        set_op($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
        set_op($urandom_range(0, 3), 1'b1, 1'b0);
`endif
      end else if (op == 3) begin
        press($urandom_range(26, 31), 0, 1'b0);
      end else begin
        press($urandom_range(0, 25), $urandom_range(0, 25), 1'($urandom_range(0, 1)));
      end
    end

    @(negedge CLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
